// File: rtl/ifm_read_ctrl_pkg.sv
// Shared types and defaults for the IFM read controller.
package ifm_read_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned MIN_W_DEF = 3;
    localparam int unsigned ST_W      = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ifm_pos_cnt.sv
// Column/row position counter over a width x height frame, wrapping at the last sample.
module ifm_pos_cnt
    import ifm_read_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last_c
);

    logic col_wrap_c;

    assign col_wrap_c = (col == width - CNT_W'(1));
    assign last_c     = col_wrap_c && (row == height - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_wrap_c) begin
                col <= '0;
                row <= last_c ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ifm_read_ctrl.sv
// Streams one IFM frame into the line buffer and flags when three same-row samples form a window.
module ifm_read_ctrl
    import ifm_read_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned MIN_W = MIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             ifm_read,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_col,
    output logic [CNT_W-1:0] win_row,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_t           state;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] height_q;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             fire;
    logic             last_c;
    logic             cfg_ok_c;
    logic             start_ok_c;
    logic             win_ok_c;

    assign cfg_ok_c   = (cfg_width >= CNT_W'(MIN_W)) && (cfg_height != '0);
    assign start_ok_c = (state == IDLE) && start && cfg_ok_c;
    assign src_ready  = (state == RUN) && !stall;
    assign fire       = src_valid && src_ready;
    assign ifm_read   = fire;
    assign busy       = (state != IDLE);
    // A window needs two earlier samples on the same row; col restarts at 0 on each row.
    assign win_ok_c   = fire && (col >= CNT_W'(2));

    ifm_pos_cnt #(.CNT_W(CNT_W)) u_pos_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok_c),
        .en     (fire),
        .width  (width_q),
        .height (height_q),
        .col    (col),
        .row    (row),
        .last_c (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= (state == IDLE) && start && !cfg_ok_c;
            case (state)
                IDLE: begin
                    if (start_ok_c) begin
                        state    <= RUN;
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                    end
                end
                RUN: begin
                    if (fire && last_c) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Window flags freeze together with the buffer while stalled.
            if (!stall) begin
                win_valid <= win_ok_c;
                if (win_ok_c) begin
                    win_col <= col - CNT_W'(2);
                    win_row <= row;
                end
            end
        end
    end

endmodule

// File: doc/ifm_read_ctrl.md
IFM_READ_CTRL -- requirements
Module: ifm_read_ctrl

Interface
REQ-001 Parameter: CNT_W, 8, width of dimension and position counters.
REQ-002 Parameter: MIN_W, 3, minimum legal row width (kernel width).
REQ-003 Ports: clk input 1, single clock for all state, rising edge.
REQ-004 Ports: rst input 1, reset, synchronous and active-high.
REQ-005 Ports: stall input 1, global pipeline freeze, shared with the IFM buffer.
REQ-006 Ports: start input 1, one-cycle request to begin a frame.
REQ-007 Ports: cfg_width input CNT_W, IFM row length in samples, sampled on accepted start.
REQ-008 Ports: cfg_height input CNT_W, IFM row count, sampled on accepted start.
REQ-009 Ports: src_valid input 1, upstream sample present.
REQ-010 Ports: src_ready output 1, controller accepts a sample this cycle.
REQ-011 Ports: ifm_read output 1, shift strobe to the IFM buffer.
REQ-012 Ports: win_valid output 1, buffer holds three same-row samples, registered.
REQ-013 Ports: win_col output CNT_W, column of the oldest sample in the valid window.
REQ-014 Ports: win_row output CNT_W, row of the valid window.
REQ-015 Ports: busy output 1, high in RUN and DONE.
REQ-016 Ports: done output 1, one-cycle end-of-frame pulse.
REQ-017 Ports: cfg_err output 1, one-cycle pulse on a rejected start.

Function
REQ-018 States SHALL be IDLE, RUN and DONE.
REQ-019 IDLE to RUN SHALL occur on start when cfg_width >= MIN_W and cfg_height >= 1, latching both values and clearing col and row to 0.
REQ-020 A start with an illegal configuration SHALL stay in IDLE and pulse cfg_err the next cycle.
REQ-021 A start while busy SHALL be ignored, with no cfg_err.
REQ-022 src_ready SHALL equal (state==RUN) && !stall, combinationally.
REQ-023 fire SHALL be src_valid && src_ready, and ifm_read SHALL equal fire combinationally, so zero latency to the buffer.
REQ-024 On fire, col SHALL increment; at col==width-1 it SHALL wrap to 0 and row SHALL increment.
REQ-025 A fire at col==width-1 and row==height-1 SHALL move RUN to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 When not stalled, win_valid SHALL be registered as fire && col>=2, with win_col<=col-2 and win_row<=row, taken from the pre-increment values.
REQ-028 While stall is high, win_valid, win_col and win_row SHALL hold their values, mirroring the frozen buffer.
REQ-029 Row wrap SHALL force win_valid low for the first two fires of each new row, so no cross-row window is marked valid.
REQ-030 A src_valid gap SHALL NOT advance counters, and win_valid SHALL be 0 the following cycle.
REQ-031 Stall SHALL NOT freeze the DONE to IDLE transition or the done and cfg_err pulses.
REQ-032 Counters SHALL be unsigned CNT_W bits, and the width-1 and height-1 compares SHALL use the latched values.

Reset
REQ-033 rst SHALL force state to IDLE and clear col, row, latched cfg, win_valid, win_col, win_row, done and cfg_err to 0.
REQ-034 rst SHALL have priority over start and stall, including mid-frame, with no done pulse.
REQ-035 After rst, src_ready, ifm_read and busy SHALL be 0.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the CNT_W and MIN_W defaults.
REQ-037 A single sub-module, ifm_pos_cnt, SHALL implement the col/row counter with wrap and last flag, enabled by fire.

Verification
REQ-038 Normal frame: width=4, height=2, src_valid held high -> 8 fires; win_valid seen at (col,row) (0,0),(1,0),(0,1),(1,1); done one cycle after the 8th fire.
REQ-039 Stall: stall high for 3 cycles mid-row at width=5 -> src_ready and ifm_read low, win_valid and win_col held, col unchanged; resumes with no lost or duplicated sample.
REQ-040 Illegal config: start with width=2 or height=0 -> cfg_err pulse, state stays IDLE, src_ready 0.
REQ-041 Row boundary: width=3, height=3 -> exactly 3 win_valid pulses, all with win_col=0, and no valid on the first two fires of any row.
REQ-042 Reset mid-frame: rst asserted at row 1, col 2 -> next cycle all outputs 0, state IDLE, no done; a new start then runs a full frame correctly.
REQ-043 Start while busy and src_valid gaps: start pulsed during RUN is ignored; src_valid toggled 1/0 gives the fire count equal to width*height and win_valid 0 after each gap cycle.
